// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// CALL pushes PC+1 and RET pops it; when full the oldest entry is overwritten.
module pc_unit_ras #(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       sig_pc_src,
  input  logic [WIDTH-1:0] J_TypeImmediate,
  input  logic [WIDTH-1:0] I_TypeImmediate,
  input  logic [WIDTH-1:0] ReturnAddress,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_plus_one,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] SRC_RET     = 3'd1;
  localparam logic [2:0] SRC_IMM     = 3'd2;
  localparam logic [2:0] SRC_SGN_IMM = 3'd3;
  localparam logic [2:0] SRC_CALL    = 3'd4;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_plus_one;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_top;
  logic [PTR_W-1:0] w_tos_up;
  logic [PTR_W-1:0] w_tos_dn;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_ret_empty;

  assign w_pc_plus_one = r_pc + WIDTH'(1);
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_top         = w_empty ? '0 : r_stack[r_tos];
  // Depth is a power of two, so pointer arithmetic wraps by truncation.
  assign w_tos_up      = r_tos + PTR_W'(1);
  assign w_tos_dn      = r_tos - PTR_W'(1);

  always_comb begin
    w_next_pc   = w_pc_plus_one;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ret_empty = 1'b0;
    case (sig_pc_src)
      SRC_RET: begin
        if (w_empty) begin
          w_next_pc   = ReturnAddress;
          w_ret_empty = 1'b1;
        end else begin
          w_next_pc = w_top;
          w_pop     = 1'b1;
        end
      end
      SRC_IMM:     w_next_pc = r_pc + J_TypeImmediate;
      SRC_SGN_IMM: w_next_pc = r_pc + I_TypeImmediate;
      SRC_CALL: begin
        w_next_pc = r_pc + J_TypeImmediate;
        w_push    = 1'b1;
      end
      default:     w_next_pc = w_pc_plus_one;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_tos   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (w_push) begin
        r_tos <= w_tos_up;
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_tos   <= w_tos_dn;
        r_count <= r_count - CNT_W'(1);
      end else if (w_ret_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) begin
      r_stack[w_tos_up] <= w_pc_plus_one;
    end
  end

  assign PC            = r_pc;
  assign pc_plus_one   = w_pc_plus_one;
  assign ras_top       = w_top;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios plus random traffic, checked every
// cycle against a queue-based return-stack model.
module tb_pc_unit_ras;

  localparam int W = 16;
  localparam int D = 8;
  localparam logic [W-1:0] RPC = '0;

  logic         clock = 1'b0;
  logic         reset;
  logic         stall;
  logic [2:0]   sig_pc_src;
  logic [W-1:0] J_TypeImmediate;
  logic [W-1:0] I_TypeImmediate;
  logic [W-1:0] ReturnAddress;
  logic [W-1:0] PC;
  logic [W-1:0] pc_plus_one;
  logic [W-1:0] ras_top;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_overflow;
  logic         ras_underflow;

  pc_unit_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .sig_pc_src(sig_pc_src),
    .J_TypeImmediate(J_TypeImmediate), .I_TypeImmediate(I_TypeImmediate),
    .ReturnAddress(ReturnAddress), .PC(PC), .pc_plus_one(pc_plus_one),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a LIFO of at most D return addresses.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_q[$];
  logic         m_ovf;
  logic         m_unf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = RPC;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      case (sig_pc_src)
        3'd1: begin
          if (m_q.size() > 0) m_pc = m_q.pop_back();
          else begin
            m_pc  = ReturnAddress;
            m_unf = 1'b1;
          end
        end
        3'd2: m_pc = m_pc + J_TypeImmediate;
        3'd3: m_pc = m_pc + I_TypeImmediate;
        3'd4: begin
          m_q.push_back(m_pc + W'(1));
          if (m_q.size() > D) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = m_pc + J_TypeImmediate;
        end
        default: m_pc = m_pc + W'(1);
      endcase
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] p1;
    logic [W-1:0] top;
    p1  = m_pc + W'(1);
    top = (m_q.size() > 0) ? m_q[$] : '0;
    chk("pc", 32'(PC), 32'(m_pc));
    chk("pc_plus_one", 32'(pc_plus_one), 32'(p1));
    chk("ras_top", 32'(ras_top), 32'(top));
    chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_q.size() == D));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic cyc(input logic r, input logic s, input logic [2:0] src,
                     input logic [W-1:0] j, input logic [W-1:0] i, input logic [W-1:0] a);
    reset = r; stall = s; sig_pc_src = src;
    J_TypeImmediate = j; I_TypeImmediate = i; ReturnAddress = a;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // Hand-computed PC values pin both the DUT and the model.
  task automatic lit_pc(input string name, input logic [W-1:0] v);
    chk({name, "_dut"}, 32'(PC), 32'(v));
    chk({name, "_model"}, 32'(m_pc), 32'(v));
  endtask

  initial begin
    logic [2:0] src;
    logic       r;
    logic       s;
    int         k;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset and sequential fetch
    cyc(1, 0, 0, 0, 0, 0);
    lit_pc("t1_reset_pc", 16'd0);
    chk("t1_empty", 32'(ras_empty), 1);
    chk("t1_full", 32'(ras_full), 0);
    chk("t1_ovf", 32'(ras_overflow), 0);
    chk("t1_unf", 32'(ras_underflow), 0);
    cyc(0, 0, 0, 0, 0, 0); lit_pc("t1_pc1", 16'd1);
    cyc(0, 0, 0, 0, 0, 0); lit_pc("t1_pc2", 16'd2);
    cyc(0, 0, 0, 0, 0, 0); lit_pc("t1_pc3", 16'd3);

    // Jumps, branches and wrap
    cyc(0, 0, 2, 16'd10, 0, 0);     lit_pc("t2_jfwd", 16'd13);
    cyc(0, 0, 2, 16'hFFF6, 0, 0);   lit_pc("t2_jback", 16'd3);
    cyc(0, 0, 3, 0, 16'd8, 0);      lit_pc("t2_br", 16'd11);
    cyc(0, 0, 2, 16'hFFF4, 0, 0);   lit_pc("t2_max", 16'hFFFF);
    cyc(0, 0, 0, 0, 0, 0);          lit_pc("t2_wrap", 16'd0);

    // Call / return
    cyc(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) cyc(0, 0, 0, 0, 0, 0);
    lit_pc("t3_start", 16'd5);
    cyc(0, 0, 4, 16'd20, 0, 0); lit_pc("t3_call1", 16'd25);
    chk("t3_top1", 32'(ras_top), 6);
    cyc(0, 0, 4, 16'd4, 0, 0);  lit_pc("t3_call2", 16'd29);
    chk("t3_top2", 32'(ras_top), 26);
    cyc(0, 0, 1, 0, 0, 16'd99); lit_pc("t3_ret1", 16'd26);
    cyc(0, 0, 1, 0, 0, 16'd99); lit_pc("t3_ret2", 16'd6);
    chk("t3_empty", 32'(ras_empty), 1);

    // Overflow then drain past empty
    cyc(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) cyc(0, 0, 4, 16'd1, 0, 0);
    chk("t4_full", 32'(ras_full), 1);
    chk("t4_ovf", 32'(ras_overflow), 1);
    cyc(0, 0, 1, 0, 0, 16'd2); lit_pc("t4_ret_first", 16'd9);
    for (int n = 0; n < 7; n++) cyc(0, 0, 1, 0, 0, 16'd2);
    lit_pc("t4_ret_last", 16'd2);
    chk("t4_empty", 32'(ras_empty), 1);
    chk("t4_unf_before", 32'(ras_underflow), 0);
    cyc(0, 0, 1, 0, 0, 16'd2); lit_pc("t4_ret_under", 16'd2);
    chk("t4_unf", 32'(ras_underflow), 1);

    // Stall freezes everything
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4, 16'd5, 0, 0); lit_pc("t5_call", 16'd7);
    for (int n = 0; n < 3; n++) cyc(0, 1, 4, 16'd5, 0, 0);
    lit_pc("t5_stalled", 16'd7);
    chk("t5_top_stalled", 32'(ras_top), 3);
    cyc(0, 0, 4, 16'd5, 0, 0); lit_pc("t5_release", 16'd12);
    chk("t5_top_release", 32'(ras_top), 8);

    // Reset beats stall mid-operation
    cyc(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) cyc(0, 0, 4, 16'd1, 0, 0);
    cyc(1, 1, 4, 16'd1, 0, 0); lit_pc("t6_reset", 16'd0);
    chk("t6_empty", 32'(ras_empty), 1);
    cyc(0, 0, 1, 0, 0, 16'd7); lit_pc("t6_ret", 16'd7);
    chk("t6_unf", 32'(ras_underflow), 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 2)      src = 3'd4;
      else if (k <= 5) src = 3'd1;
      else if (k == 6) src = 3'd2;
      else if (k == 7) src = 3'd3;
      else if (k == 8) src = 3'd0;
      else             src = 3'($urandom_range(5, 7));
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 4) == 0);
      cyc(r, s, src, W'($urandom), W'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
